// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_pkg
//  Purpose  : Shared RV32 front-end definitions: data width, canonical NOP,
//             and the fetch-stage state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the instruction-memory request/ack bus, the decoder
//             hand-off and the branch redirect into one port.
//             master = fetch stage, slave = memory/decoder side.
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import rv32_pkg::*;

    // instruction memory
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    // decoder side
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_valid;

    modport master (
        output imem_req, imem_addr, inst, inst_pc, inst_valid,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_pc, inst_valid,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the PC, issues word requests over
//             a req/ack bus, presents {inst, inst_pc} to the decoder with a
//             one-entry skid buffer for stalls, and redirects on branches.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = rv32_pkg::NOP_INST
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_unit_if.master  bus
);

    localparam int XLEN = rv32_pkg::XLEN;

    localparam logic [1:0] ST_IDLE  = rv32_pkg::IDLE;
    localparam logic [1:0] ST_FETCH = rv32_pkg::FETCH;
    localparam logic [1:0] ST_HOLD  = rv32_pkg::HOLD;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pend_addr;   // address of the in-flight request being discarded
    logic            r_discard;

    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_inst_valid;

    logic [XLEN-1:0] r_skid_inst;
    logic [XLEN-1:0] r_skid_pc;
    logic            r_skid_full;

    logic            w_in_fetch;
    logic            w_ack;
    logic            w_slot_free;
    logic            w_accept;
    logic            w_load_out;
    logic            w_load_skid;
    logic            w_unskid;
    logic            w_consume;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_next;
    logic            w_unused_pc_lsb;

    assign w_in_fetch  = (r_state == ST_FETCH);
    assign w_ack       = w_in_fetch && bus.imem_ack;
    assign w_slot_free = !r_inst_valid || !bus.stall;
    // Returned word is kept only if it belongs to the current PC stream.
    assign w_accept    = w_ack && !r_discard && !bus.redirect;
    assign w_load_out  = w_accept && w_slot_free;
    assign w_load_skid = w_accept && !w_slot_free;
    assign w_unskid    = (r_state == ST_HOLD) && r_skid_full && !bus.stall && !bus.redirect;
    assign w_consume   = r_inst_valid && !bus.stall;
    assign w_target    = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign w_pc_next   = r_fetch_pc + 32'd4;

    // Low address bits of the redirect target are architecturally ignored.
    assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];

    // While a redirected request is still outstanding the old address must
    // stay on the bus, so it is held separately from the already-updated PC.
    assign bus.imem_req   = w_in_fetch;
    assign bus.imem_addr  = r_discard ? r_pend_addr : r_fetch_pc;

    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.inst_valid = r_inst_valid;

    // Fetch state machine, program counter and stale-response tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_pend_addr <= RESET_PC;
            r_discard   <= 1'b0;
        end else if (bus.redirect) begin
            r_fetch_pc <= w_target;
            r_state    <= ST_FETCH;
            if (w_in_fetch) begin
                // Without an ack this cycle the request stays outstanding and
                // its eventual response must be thrown away.
                r_discard <= !bus.imem_ack;
                if (!r_discard && !bus.imem_ack) begin
                    r_pend_addr <= r_fetch_pc;
                end
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_ack && r_discard) begin
                        r_discard <= 1'b0;
                    end
                    if (w_accept) begin
                        r_fetch_pc <= w_pc_next;
                    end
                    if (w_load_skid) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_unskid) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoder output register and skid buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst       <= NOP_INST;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= RESET_PC;
            r_skid_full  <= 1'b0;
        end else if (bus.redirect) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_skid_full  <= 1'b0;
        end else begin
            if (w_unskid) begin
                r_inst       <= r_skid_inst;
                r_inst_pc    <= r_skid_pc;
                r_inst_valid <= 1'b1;
                r_skid_full  <= 1'b0;
            end else if (w_load_out) begin
                r_inst       <= bus.imem_rdata;
                r_inst_pc    <= r_fetch_pc;
                r_inst_valid <= 1'b1;
            end else if (w_consume) begin
                r_inst       <= NOP_INST;
                r_inst_valid <= 1'b0;
            end
            if (w_load_skid) begin
                r_skid_inst <= bus.imem_rdata;
                r_skid_pc   <= r_fetch_pc;
                r_skid_full <= 1'b1;
            end
        end
    end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: directed scenarios plus a
//             randomized stall/redirect stream checked against an in-order
//             PC-sequence model of the delivered instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if bus0();
    fetch_unit_if bus1();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int mem_wait = 0;
    int wait_cnt = 0;

    // Instruction memory contents: two fixed words, a bijective pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        if (a == 32'h0000_0004) return 32'h00A0_0113;
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    // Memory responders: dut0 answers after mem_wait idle cycles, dut1 is zero-wait.
    task automatic drive_mem();
        if (bus0.imem_req) begin
            if (wait_cnt >= mem_wait) begin
                bus0.imem_ack   = 1'b1;
                bus0.imem_rdata = mem_word(bus0.imem_addr);
                wait_cnt        = 0;
            end else begin
                bus0.imem_ack   = 1'b0;
                bus0.imem_rdata = 32'hDEAD_BEEF;
                wait_cnt        = wait_cnt + 1;
            end
        end else begin
            bus0.imem_ack   = 1'b0;
            bus0.imem_rdata = 32'hDEAD_BEEF;
        end
        bus1.imem_ack   = bus1.imem_req;
        bus1.imem_rdata = mem_word(bus1.imem_addr);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drive_mem();
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus0.stall       = 1'b0;
        bus0.redirect    = 1'b0;
        bus0.redirect_pc = 32'h0;
        bus0.imem_ack    = 1'b0;
        bus0.imem_rdata  = 32'h0;
        bus1.stall       = 1'b0;
        bus1.redirect    = 1'b0;
        bus1.redirect_pc = 32'h0;
        bus1.imem_ack    = 1'b0;
        bus1.imem_rdata  = 32'h0;
        wait_cnt         = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus0.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %0b expected 0", bus0.imem_req);
        end
        n_cmp++;
        if (bus0.imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 00000000", bus0.imem_addr);
        end
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst, bus0.inst_pc} !== {1'b0, NOP, 32'h0}) begin
            n_fail++; $display("FAIL reset_out: got v=%0b inst=%h pc=%h expected v=0 inst=%h pc=0",
                               bus0.inst_valid, bus0.inst, bus0.inst_pc, NOP);
        end
        n_cmp++;
        if ({bus1.imem_addr, bus1.inst_pc} !== {32'hFFFF_FFF8, 32'hFFFF_FFF8}) begin
            n_fail++; $display("FAIL reset_pc_param: got addr=%h pc=%h expected fffffff8",
                               bus1.imem_addr, bus1.inst_pc);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        mem_wait = 0;
        n_cmp++;
        if (bus0.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL zw_idle_req: got %0b expected 0", bus0.imem_req);
        end
        tick();
        n_cmp++;
        if ({bus0.imem_req, bus0.imem_addr, bus0.inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL zw_first_req: got req=%0b addr=%h v=%0b expected req=1 addr=0 v=0",
                               bus0.imem_req, bus0.imem_addr, bus0.inst_valid);
        end
        tick();
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst, bus0.inst_pc, bus0.imem_req, bus0.imem_addr}
                !== {1'b1, 32'h0050_0093, 32'h0, 1'b1, 32'h4}) begin
            n_fail++; $display("FAIL zw_word0: got v=%0b inst=%h pc=%h req=%0b addr=%h expected 1 00500093 0 1 4",
                               bus0.inst_valid, bus0.inst, bus0.inst_pc, bus0.imem_req, bus0.imem_addr);
        end
        tick();
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst, bus0.inst_pc, bus0.imem_req}
                !== {1'b1, 32'h00A0_0113, 32'h4, 1'b1}) begin
            n_fail++; $display("FAIL zw_word1: got v=%0b inst=%h pc=%h req=%0b expected 1 00a00113 4 1",
                               bus0.inst_valid, bus0.inst, bus0.inst_pc, bus0.imem_req);
        end
    endtask

    task automatic test_wait2();
        logic exp_v;
        do_reset();
        mem_wait = 2;
        tick();
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 3; c++) begin
                exp_v = (w > 0) && (c == 0);
                n_cmp++;
                if ({bus0.imem_req, bus0.imem_addr, bus0.inst_valid} !== {1'b1, 32'(4 * w), exp_v}) begin
                    n_fail++; $display("FAIL wait2_w%0d_c%0d: got req=%0b addr=%h v=%0b expected req=1 addr=%h v=%0b",
                                       w, c, bus0.imem_req, bus0.imem_addr, bus0.inst_valid, 32'(4 * w), exp_v);
                end
                if (exp_v) begin
                    n_cmp++;
                    if (bus0.inst_pc !== 32'(4 * (w - 1))) begin
                        n_fail++; $display("FAIL wait2_pc_w%0d: got %h expected %h", w, bus0.inst_pc, 32'(4 * (w - 1)));
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        mem_wait = 0;
        tick();
        tick();
        bus0.stall = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({bus0.imem_req, bus0.inst_valid, bus0.inst_pc, bus0.inst} !== {1'b0, 1'b1, 32'h0, mem_word(32'h0)}) begin
                n_fail++; $display("FAIL hold_k%0d: got req=%0b v=%0b pc=%h inst=%h expected req=0 v=1 pc=0 inst=%h",
                                   k, bus0.imem_req, bus0.inst_valid, bus0.inst_pc, bus0.inst, mem_word(32'h0));
            end
            if (k == 4) bus0.stall = 1'b0;
            tick();
        end
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst_pc, bus0.inst, bus0.imem_req, bus0.imem_addr}
                !== {1'b1, 32'h4, mem_word(32'h4), 1'b1, 32'h8}) begin
            n_fail++; $display("FAIL hold_release: got v=%0b pc=%h inst=%h req=%0b addr=%h expected 1 4 %h 1 8",
                               bus0.inst_valid, bus0.inst_pc, bus0.inst, bus0.imem_req, bus0.imem_addr, mem_word(32'h4));
        end
        tick();
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst_pc} !== {1'b1, 32'h8}) begin
            n_fail++; $display("FAIL hold_resume: got v=%0b pc=%h expected v=1 pc=8", bus0.inst_valid, bus0.inst_pc);
        end
    endtask

    task automatic test_redirect_discard();
        do_reset();
        mem_wait = 2;
        for (int k = 0; k < 4; k++) tick();
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0103;
        tick();
        bus0.redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({bus0.imem_req, bus0.imem_addr, bus0.inst_valid} !== {1'b1, 32'h4, 1'b0}) begin
                n_fail++; $display("FAIL discard_old_k%0d: got req=%0b addr=%h v=%0b expected req=1 addr=4 v=0",
                                   k, bus0.imem_req, bus0.imem_addr, bus0.inst_valid);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({bus0.imem_req, bus0.imem_addr, bus0.inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
                n_fail++; $display("FAIL discard_tgt_k%0d: got req=%0b addr=%h v=%0b expected req=1 addr=100 v=0",
                                   k, bus0.imem_req, bus0.imem_addr, bus0.inst_valid);
            end
            tick();
        end
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst_pc, bus0.inst} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            n_fail++; $display("FAIL discard_tgt_word: got v=%0b pc=%h inst=%h expected v=1 pc=100 inst=%h",
                               bus0.inst_valid, bus0.inst_pc, bus0.inst, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_stall_ack();
        do_reset();
        mem_wait = 0;
        tick();
        tick();
        bus0.stall       = 1'b1;
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0200;
        tick();
        bus0.stall    = 1'b0;
        bus0.redirect = 1'b0;
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst, bus0.imem_req, bus0.imem_addr} !== {1'b0, NOP, 1'b1, 32'h200}) begin
            n_fail++; $display("FAIL redir_wins: got v=%0b inst=%h req=%0b addr=%h expected v=0 inst=%h req=1 addr=200",
                               bus0.inst_valid, bus0.inst, bus0.imem_req, bus0.imem_addr, NOP);
        end
        tick();
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst_pc, bus0.inst} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
            n_fail++; $display("FAIL redir_tgt: got v=%0b pc=%h inst=%h expected v=1 pc=200 inst=%h",
                               bus0.inst_valid, bus0.inst_pc, bus0.inst, mem_word(32'h200));
        end
        tick();
        n_cmp++;
        if ({bus0.inst_valid, bus0.inst_pc} !== {1'b1, 32'h204}) begin
            n_fail++; $display("FAIL redir_next: got v=%0b pc=%h expected v=1 pc=204", bus0.inst_valid, bus0.inst_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            e = 32'hFFFF_FFF8 + 32'(4 * k);
            n_cmp++;
            if ({bus1.inst_valid, bus1.inst_pc, bus1.inst} !== {1'b1, e, mem_word(e)}) begin
                n_fail++; $display("FAIL wrap_k%0d: got v=%0b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                                   k, bus1.inst_valid, bus1.inst_pc, bus1.inst, e, mem_word(e));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mem_wait = 2;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_cnt = 0;
        n_cmp++;
        if ({bus0.imem_req, bus0.imem_addr, bus0.inst_valid, bus0.inst, bus0.inst_pc}
                !== {1'b0, 32'h0, 1'b0, NOP, 32'h0}) begin
            n_fail++; $display("FAIL mid_reset: got req=%0b addr=%h v=%0b inst=%h pc=%h expected 0 0 0 %h 0",
                               bus0.imem_req, bus0.imem_addr, bus0.inst_valid, bus0.inst, bus0.inst_pc, NOP);
        end
    endtask

    // Model: delivered instructions form consecutive PCs from the last
    // redirect target (or reset PC); each carries the memory word at its PC.
    task automatic test_random();
        logic [31:0] exp_pc, prev_inst, prev_pc;
        logic        prev_hold, prev_valid, v, s, r;
        int          consumed;
        for (int seg = 0; seg < 3; seg++) begin
            do_reset();
            mem_wait  = int'($urandom_range(0, 2));
            exp_pc    = 32'h0;
            prev_hold = 1'b0;
            prev_inst = 32'h0;
            prev_pc   = 32'h0;
            prev_valid = 1'b0;
            consumed  = 0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                v = bus0.inst_valid;
                n_cmp++;
                if (bus0.imem_addr[1:0] !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_addr_align: got %h", bus0.imem_addr);
                end
                if (prev_hold) begin
                    n_cmp++;
                    if ({v, bus0.inst, bus0.inst_pc} !== {prev_valid, prev_inst, prev_pc}) begin
                        n_fail++; $display("FAIL rnd_hold: got v=%0b inst=%h pc=%h expected v=%0b inst=%h pc=%h",
                                           v, bus0.inst, bus0.inst_pc, prev_valid, prev_inst, prev_pc);
                    end
                end
                if (!v) begin
                    n_cmp++;
                    if (bus0.inst !== NOP) begin
                        n_fail++; $display("FAIL rnd_nop: got %h expected %h", bus0.inst, NOP);
                    end
                end
                s = ($urandom_range(0, 99) < 30);
                r = ($urandom_range(0, 99) < 4);
                bus0.stall       = s;
                bus0.redirect    = r;
                bus0.redirect_pc = $urandom;
                if (v && !s) begin
                    n_cmp++;
                    if ({bus0.inst_pc, bus0.inst} !== {exp_pc, mem_word(exp_pc)}) begin
                        n_fail++; $display("FAIL rnd_stream: got pc=%h inst=%h expected pc=%h inst=%h",
                                           bus0.inst_pc, bus0.inst, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc   = exp_pc + 32'd4;
                    consumed = consumed + 1;
                end
                if (r) exp_pc = bus0.redirect_pc & 32'hFFFF_FFFC;
                prev_hold  = v && s && !r;
                prev_valid = v;
                prev_inst  = bus0.inst;
                prev_pc    = bus0.inst_pc;
                tick();
            end
            bus0.stall    = 1'b0;
            bus0.redirect = 1'b0;
            n_cmp++;
            if (consumed < 30) begin
                n_fail++; $display("FAIL rnd_progress_seg%0d: got %0d delivered expected at least 30", seg, consumed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall_hold();
        test_redirect_discard();
        test_redirect_stall_ack();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that directly feeds the decoder. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It presents one 32-bit instruction plus its PC to the decoder, holds it under stall, and redirects to a new PC on a taken branch or jump.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, value driven on `inst` when no valid instruction is held (addi x0,x0,0)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, level
- imem_addr  out  32  word address, bits [1:0] always 0
- imem_ack  in  1  one-cycle acknowledge; `imem_rdata` valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- stall  in  1  downstream cannot accept; `inst`/`inst_pc`/`inst_valid` must hold
- redirect  in  1  one-cycle pulse, taken branch/jump
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- inst  out  32  instruction to decoder
- inst_pc  out  32  PC of `inst`
- inst_valid  out  1  `inst` is a real instruction

## Operation
- Reset values:
  - state=IDLE
  - fetch_pc=RESET_PC; imem_req=0; imem_addr=RESET_PC
  - inst=NOP_INST; inst_pc=RESET_PC; inst_valid=0
  - skid buffer empty; discard=0
- State machine:
  - IDLE: req=0; always goes to FETCH next cycle.
  - FETCH: req=1; addr=fetch_pc, stable until the ack cycle.
  - HOLD: req=0; skid buffer full, waiting for stall to drop.
- Consume rule: the decoder takes `inst` at every edge where inst_valid=1 and stall=0. The output slot is free if inst_valid=0 or stall=0.
- FETCH, ack with discard=0 and no redirect:
  - Slot free: load the output with {rdata, fetch_pc}, set inst_valid=1, fetch_pc+=4, stay in FETCH (back-to-back).
  - Slot busy: store {rdata, fetch_pc} in the skid buffer, fetch_pc+=4, go to HOLD.
- HOLD: when stall=0, move the skid buffer into the output (inst_valid=1), empty the buffer, go to FETCH.
- Redirect has the highest priority over stall and ack. At the next edge:
  - inst_valid=0, inst=NOP_INST, skid buffer emptied.
  - fetch_pc={redirect_pc[31:2],2'b00}.
  - HOLD or IDLE go to FETCH.
- Redirect in FETCH without ack that cycle: set discard=1. Keep req and addr at the old address until ack. Drop that ack's data, clear discard, then request the target next cycle.
- Redirect in FETCH with ack the same cycle: drop the data, request the target next cycle.
- A second redirect while discard=1 updates fetch_pc only; discard stays 1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- rst mid-operation: return to reset values at that edge; any outstanding request is abandoned (memory is reset together).

## Timing
- rst low at edge E0 → IDLE during cycle 1 → FETCH at E1 (req high in cycle 2).
- With zero-wait memory (ack in the req cycle), inst_valid=1 after E2.
- Zero-wait throughput is 1 instruction/cycle. An N-wait memory gives 1 per N+1 cycles.
- Redirect at edge Er: the target request is visible in cycle Er+1 if no request was pending. With zero-wait memory, the target instruction is valid after Er+2.
- imem_req drops for exactly the HOLD duration. It never glitches between ack and the next request while in FETCH.
- All outputs are registered except imem_req/imem_addr, which are decoded from state and fetch_pc registers only.

## Structure
- Shared package `rv32_pkg`:
  - `fetch_state_t` enum (IDLE, FETCH, HOLD)
  - NOP_INST constant
  - XLEN=32
- Single module, no sub-module. The skid buffer is one register pair plus a full flag, kept inline.

## Test plan
- Reset then zero-wait memory returning 32'h00500093 at 0, 32'h00A00113 at 4 → inst_valid after E2; inst_pc 0 then 4 on consecutive cycles; imem_req continuous.
- 2-wait memory → imem_addr stable 3 cycles per word; one valid instruction every 3 cycles; inst_valid=0 in between.
- stall held 4 cycles while an ack arrives → output holds; HOLD entered with req=0. After stall drops, the buffered word appears next cycle with correct inst_pc, then fetching resumes at +4.
- redirect to 32'h0000_0103 during an outstanding 2-wait request → that ack is discarded; next request addr=32'h0000_0100; inst_valid=0 until the target word returns.
- redirect asserted together with stall and ack → redirect wins: output becomes NOP/invalid, skid buffer empty, next addr=target.
- RESET_PC=32'hFFFF_FFF8 → fetches FFF8, FFFC, then 0000_0000; rst asserted mid-request → all outputs return to reset values on the next edge.
